// File: rtl/seq4_sort_stream_pkg.sv
// rtl/seq4_sort_stream_pkg.sv - shared constants and types for the 4-sample stream sorter
package seq4_sort_pkg;

  // Frame length and width of the fill/drain counters (must hold 0..N)
  localparam int N  = 4;
  localparam int CW = 3;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Per-slot update choice during an insert
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_V    = 2'd1,
    SEL_PREV = 2'd2
  } sel_t;

endpackage

// File: rtl/seq4_sort_stream_if.sv
// rtl/seq4_sort_stream_if.sv - upstream/downstream handshake bundle for the sorter
interface seq4_sort_stream_if #(
  parameter int DW = 3
);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  // Environment side: produces samples, consumes sorted words
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // Sorter side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/seq4_insert_cell.sv
// rtl/seq4_insert_cell.sv - per-slot insert decision for the sorted slot array
module seq4_insert_cell
  import seq4_sort_pkg::*;
#(
  parameter int DW = 3
) (
  input  logic [DW-1:0] v,
  input  logic [DW-1:0] s_cur,
  input  logic [DW-1:0] s_prev,
  input  logic          slot_valid,
  input  logic          prev_valid,
  output sel_t          sel
);

  logic le_cur;
  logic le_prev;

  // Held slots are sorted, so the "<= v" slots form a prefix. A slot in that
  // prefix keeps its value; the first slot past it takes v; the rest shift up.
  // Slot 0 is fed prev_valid=1, s_prev=0 so it always sees "prefix before me".
  assign le_cur  = slot_valid && (s_cur <= v);
  assign le_prev = prev_valid && (s_prev <= v);

  // Select hold / new sample / upper neighbour's old value
  always_comb begin
    sel = SEL_HOLD;
    if (!le_cur) begin
      sel = le_prev ? SEL_V : SEL_PREV;
    end
  end

endmodule

// File: rtl/seq4_sort_stream.sv
// rtl/seq4_sort_stream.sv - collects 4 samples, insertion-sorts on arrival, replays smallest-first
module seq4_sort_stream
  import seq4_sort_pkg::*;
#(
  parameter int DW = 3
) (
  input logic                clk,
  input logic                rst,
  seq4_sort_stream_if.slave  bus
);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   fill_q;
  logic [CW-1:0]   rem_q;
  logic [DW-1:0]   slot_q     [N];
  logic [DW-1:0]   prev_data  [N];
  logic [N-1:0]    prev_valid;
  logic [N-1:0]    slot_valid;
  sel_t            sel        [N];

  logic            in_ready;
  logic            out_valid;
  logic            out_last;
  logic [DW-1:0]   out_data;
  logic            in_hs;
  logic            out_hs;

  assign in_hs  = bus.in_valid  && in_ready;
  assign out_hs = bus.out_ready && out_valid;

  for (genvar i = 0; i < N; i++) begin : g_cell
    if (i == 0) begin : g_first
      assign prev_data[i]  = '0;
      assign prev_valid[i] = 1'b1;
    end else begin : g_rest
      assign prev_data[i]  = slot_q[i-1];
      assign prev_valid[i] = CW'(i - 1) < fill_q;
    end
    assign slot_valid[i] = CW'(i) < fill_q;

    seq4_insert_cell #(.DW(DW)) u_cell (
      .v          (bus.in_data),
      .s_cur      (slot_q[i]),
      .s_prev     (prev_data[i]),
      .slot_valid (slot_valid[i]),
      .prev_valid (prev_valid[i]),
      .sel        (sel[i])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; outputs are purely state-derived
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (bus.in_valid && (fill_q == CW'(N - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = slot_q[0];
        out_last  = (rem_q == CW'(1));
        if (bus.out_ready && (rem_q == CW'(1))) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Slot array and counters: insert on input handshake, shift down on output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      rem_q  <= '0;
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= '0;
      end
    end else if (in_hs) begin
      for (int i = 0; i < N; i++) begin
        case (sel[i])
          SEL_V:    slot_q[i] <= bus.in_data;
          SEL_PREV: slot_q[i] <= prev_data[i];
          default:  slot_q[i] <= slot_q[i];
        endcase
      end
      fill_q <= fill_q + CW'(1);
      if (fill_q == CW'(N - 1)) begin
        rem_q <= CW'(N);
      end
    end else if (out_hs) begin
      for (int i = 0; i < N - 1; i++) begin
        slot_q[i] <= slot_q[i+1];
      end
      slot_q[N-1] <= '0;
      rem_q       <= rem_q - CW'(1);
      if (rem_q == CW'(1)) begin
        fill_q <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_seq4_sort_stream.sv
// tb/tb_seq4_sort_stream.sv - self-checking bench for the 4-sample stream sorter
module tb_seq4_sort_stream;

  localparam int DW = 3;

  typedef logic [3:0][DW-1:0] frame_t;
  typedef struct {
    frame_t in_v;
    frame_t exp_v;
    string  name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq4_sort_stream_if #(.DW(DW)) bus ();

  seq4_sort_stream #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input int a, input int b, input int c, input int d);
    frame_t f;
    f[0] = DW'(a);
    f[1] = DW'(b);
    f[2] = DW'(c);
    f[3] = DW'(d);
    return f;
  endfunction

  // Reference: bucket the four samples by value and read buckets in ascending order
  function automatic frame_t ref_sort(input frame_t in_v);
    frame_t f;
    int     idx;
    f   = '0;
    idx = 0;
    for (int val = 0; val < (1 << DW); val++) begin
      for (int j = 0; j < 4; j++) begin
        if (int'(in_v[j]) == val) begin
          f[idx] = DW'(val);
          idx++;
        end
      end
    end
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send(input int v, input int gap);
    logic rdy;
    int   n;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = DW'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(v);
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 20) begin
      rdy = bus.in_ready;
      @(negedge clk);
      n++;
    end
    if (!rdy) check("send_timeout", 0, 1);
  endtask

  task automatic recv(input int exp, input logic exp_last, input int bp, input string name);
    logic done;
    int   n;
    done = 1'b0;
    n    = 0;
    while (!done && n < 50) begin
      bus.out_ready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        check({name, "_data"}, 32'(bus.out_data), 32'(exp));
        check({name, "_last"}, 32'(bus.out_last), 32'(exp_last));
        done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.out_ready = 1'b0;
    if (!done) check({name, "_recv_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input frame_t in_v, input frame_t exp_v, input int gap_max,
                           input int bp, input string name);
    for (int i = 0; i < 4; i++) begin
      send(int'(in_v[i]), (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
    bus.in_valid = 1'b0;
    check({name, "_lat_valid"}, 32'(bus.out_valid), 1);
    check({name, "_lat_inrdy"}, 32'(bus.in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      recv(int'(exp_v[i]), (i == 3), bp, name);
    end
    check({name, "_bubble_inrdy"}, 32'(bus.in_ready), 1);
    check({name, "_bubble_oval"}, 32'(bus.out_valid), 0);
  endtask

  vec_t   tbl [5];
  frame_t fr;
  int     cnt;

  initial begin
    tbl[0] = '{mk(5, 2, 7, 1), mk(1, 2, 5, 7), "basic"};
    tbl[1] = '{mk(3, 3, 0, 3), mk(0, 3, 3, 3), "dup"};
    tbl[2] = '{mk(6, 6, 6, 6), mk(6, 6, 6, 6), "equal"};
    tbl[3] = '{mk(0, 1, 2, 3), mk(0, 1, 2, 3), "sorted"};
    tbl[4] = '{mk(7, 6, 5, 4), mk(4, 5, 6, 7), "reverse"};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_frame(tbl[t].in_v, tbl[t].exp_v, 0, 0, tbl[t].name);
    end

    // Backpressure: stall 5 cycles in DRAIN with upstream trying to push
    send(4, 0); send(0, 0); send(6, 0); send(2, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(5);
    for (int c = 0; c < 5; c++) begin
      bus.out_ready = 1'b0;
      check("bp_data", 32'(bus.out_data), 0);
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_inrdy", 32'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    recv(0, 1'b0, 0, "bp0");
    recv(2, 1'b0, 0, "bp1");
    recv(4, 1'b0, 0, "bp2");
    recv(6, 1'b1, 0, "bp3");

    // Free-running counter source keeps in_valid high through DRAIN
    cnt = 6;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        send(cnt, 0);
        cnt = (cnt + 1) % 8;
      end
      bus.in_data = DW'(cnt);
      fr = (f == 0) ? mk(0, 1, 6, 7) : mk(2, 3, 4, 5);
      for (int i = 0; i < 4; i++) begin
        recv(int'(fr[i]), (i == 3), 0, "cnt");
      end
      check("cnt_bubble_oval", 32'(bus.out_valid), 0);
      check("cnt_bubble_inrdy", 32'(bus.in_ready), 1);
    end
    bus.in_valid = 1'b0;

    // Reset mid-FILL
    send(3, 0); send(5, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstfill_oval", 32'(bus.out_valid), 0);
    check("rstfill_inrdy", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-DRAIN
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    bus.in_valid = 1'b0;
    recv(1, 1'b0, 0, "rstdrain_first");
    rst = 1'b1;
    #1;
    check("rstdrain_oval", 32'(bus.out_valid), 0);
    check("rstdrain_inrdy", 32'(bus.in_ready), 1);
    check("rstdrain_data", 32'(bus.out_data), 0);
    check("rstdrain_last", 32'(bus.out_last), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(mk(7, 1, 1, 0), mk(0, 1, 1, 7), 0, 0, "after_rst");

    // Upstream gaps: in_valid alternates
    send(2, 0); send(1, 1); send(3, 1); send(0, 1);
    bus.in_valid = 1'b0;
    check("gap_lat_valid", 32'(bus.out_valid), 1);
    recv(0, 1'b0, 0, "gap0");
    recv(1, 1'b0, 0, "gap1");
    recv(2, 1'b0, 0, "gap2");
    recv(3, 1'b1, 0, "gap3");

    // Random frames with random gaps and random backpressure
    for (int f = 0; f < 40; f++) begin
      fr = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      run_frame(fr, ref_sort(fr), 2, 1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
